lfsr_seq_ctrl: RTL and testbench
================================

Name: lfsr_seq_ctrl

Overview:
Sequencer that owns one Fibonacci LFSR and runs it as a managed pseudo-random source. A requester starts a run with a seed and a word count. The block then streams exactly that many LFSR states over a valid/ready interface and reports done, a seed error, and the measured sequence period. It sits between test/stimulus masters and the LFSR datapath, so no master manipulates the shift register directly.

Parameters:
WIDTH, 4, LFSR width; only 4 and 8 are legal, any other value is an elaboration error.
CNT_W, 16, width of the count and period fields.

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  run request, sampled only in IDLE
seed  input  WIDTH  initial LFSR state, sampled with start
count  input  CNT_W  number of words to emit, sampled with start
abort  input  1  terminate the current run
out_data  output  WIDTH  current LFSR state
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts out_data
busy  output  1  high in LOAD, RUN and DONE
done  output  1  one-cycle pulse at normal completion
err  output  1  one-cycle pulse when a start is rejected
period  output  CNT_W  measured steps to return to seed
period_valid  output  1  period holds a measurement (sticky)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, LFSR=0, remaining=0, steps=0. All outputs are 0.
- rst has priority over every other input in every state. Reset mid-run drops out_valid on the next edge and no done is produced.
- Next-state function:
  - WIDTH=4: next = {q[2:0], q[3]^q[2]}.
  - WIDTH=8: next = {q[6:0], q[7]^q[5]^q[2]^q[1]}.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE, start=1 with seed==0: err pulses on the next cycle and the FSM stays in IDLE. The all-zero state is a lockup.
- IDLE, start=1 with count==0 and seed!=0: go to DONE. done pulses; out_valid never asserts.
- IDLE, start=1 otherwise:
  - LFSR<=seed, seed_q<=seed, remaining<=count, steps<=0.
  - period<=0 and period_valid<=0.
  - Go to LOAD.
- start outside IDLE is ignored.
- LOAD: one cycle with busy=1 and out_valid=0, then go to RUN. Latency from start to the first out_valid is 2 cycles.
- RUN:
  - out_valid=1 and out_data=LFSR. The first word equals seed.
  - A transfer happens when out_valid&&out_ready.
  - With out_ready=0, out_data and LFSR are held stable.
- On each transfer:
  - LFSR<=next, remaining<=remaining-1, steps<=steps+1 (saturating at all-ones).
  - If remaining==1, go to DONE.
  - If next==seed_q and period_valid==0: period<=steps+1 and period_valid<=1.
- abort in RUN or LOAD: go to IDLE on the next edge, with out_valid=0 from that edge. No done pulse. period/period_valid keep their current values. abort wins over a simultaneous transfer, so that word is not counted and the LFSR does not step.
- abort in IDLE or DONE has no effect.
- DONE: done=1 for exactly one cycle, busy=1, then go to IDLE. A new start is accepted on the first IDLE cycle.
- out_valid is never high outside RUN.
- period and period_valid persist in IDLE until the next accepted start or reset.
- Run length: remaining uses the full CNT_W bits, so count=2^CNT_W-1 is legal.

Decomposition:
- Shared package lfsr_pkg holds:
  - the state encoding constants (IDLE=0, LOAD=1, RUN=2, DONE=3);
  - the tap constants per width (4: bits 3,2; 8: bits 7,5,2,1);
  - the legal-width check.
- One sub-module, lfsr_core: WIDTH register with synchronous rst, load/load_val, step enable, and a combinational next output used for the period compare.
- The controller FSM, counters and period logic live in lfsr_seq_ctrl.

Test Plan:
- WIDTH=4, seed=4'b0001, count=3, out_ready=1: out_valid asserts 2 cycles after start, and out_data is 0001, 0010, 0100 on consecutive cycles. done pulses 1 cycle after the third word, then busy=0.
- Same run with out_ready low for 3 cycles on the second word: 0010 is held for 4 cycles and is transferred once. Output order is unchanged.
- seed=0, count=5: err pulses once, busy stays 0, out_valid stays 0. count=0 with seed=4'b0011: done pulses and no valid is seen.
- seed=4'b0001, count=20, ready=1:
  - words 1-15 are 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000;
  - word 16 is 0001 again;
  - period=15 and period_valid=1 after the 15th transfer; done after 20 transfers.
- abort asserted together with the transfer of word 2: out_valid=0 on the next cycle, no done, and a following start with seed=4'b1000 emits 1000 first.
- rst during RUN on word 5: on the next edge all outputs are 0 and state is IDLE. A start 1 cycle later behaves exactly as from power-up.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared state encoding, LFSR tap masks and width legality for the LFSR sequencer.
package lfsr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [7:0] TAPS_W4 = 8'b0000_1100;
   localparam logic [7:0] TAPS_W8 = 8'b1010_0110;

   function automatic bit width_ok(input int w);
      return (w == 4) || (w == 8);
   endfunction

   function automatic logic [7:0] tap_mask(input int w);
      return (w == 8) ? TAPS_W8 : TAPS_W4;
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci LFSR register with load, step enable and a combinational next-state view.
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int WIDTH = 4
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_step,
   output logic [WIDTH-1:0] o_q,
   output logic [WIDTH-1:0] o_next
);

   localparam logic [7:0] TAPS = tap_mask(WIDTH);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_taps;

   assign w_taps = TAPS[WIDTH-1:0];
   assign o_next = {r_q[WIDTH-2:0], ^(r_q & w_taps)};
   assign o_q    = r_q;

   always_ff @(posedge clk) begin
      if (rst)
         r_q <= '0;
      else if (i_load)
         r_q <= i_load_val;
      else if (i_step)
         r_q <= o_next;
   end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: runs one LFSR as a managed source, streaming a requested number of states
// over valid/ready and measuring the period back to the seed.
module lfsr_seq_ctrl
   import lfsr_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] seed,
   input  logic [CNT_W-1:0] count,
   input  logic             abort,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] period,
   output logic             period_valid
);

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("lfsr_seq_ctrl: WIDTH must be 4 or 8");
   end

   state_t           r_state;
   logic [WIDTH-1:0] r_seed;
   logic [CNT_W-1:0] r_rem;
   logic [CNT_W-1:0] r_steps;
   logic [CNT_W-1:0] r_period;
   logic             r_period_valid;
   logic             r_out_valid;
   logic             r_busy;
   logic             r_done;
   logic             r_err;

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_next;
   logic             w_load;
   logic             w_step;
   logic [CNT_W-1:0] w_steps_inc;

   assign w_load      = (r_state == IDLE) && start && (seed != '0) && (count != '0);
   // abort beats a simultaneous handshake, so the word is neither counted nor stepped
   assign w_step      = (r_state == RUN) && r_out_valid && out_ready && !abort;
   assign w_steps_inc = (&r_steps) ? r_steps : r_steps + 1'b1;

   lfsr_core #(.WIDTH(WIDTH)) u_core (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (seed),
      .i_step     (w_step),
      .o_q        (w_q),
      .o_next     (w_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_seed         <= '0;
         r_rem          <= '0;
         r_steps        <= '0;
         r_period       <= '0;
         r_period_valid <= 1'b0;
         r_out_valid    <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_err          <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  if (seed == '0) begin
                     r_err <= 1'b1;
                  end else if (count == '0) begin
                     r_state <= DONE;
                     r_busy  <= 1'b1;
                     r_done  <= 1'b1;
                  end else begin
                     r_state        <= LOAD;
                     r_busy         <= 1'b1;
                     r_seed         <= seed;
                     r_rem          <= count;
                     r_steps        <= '0;
                     r_period       <= '0;
                     r_period_valid <= 1'b0;
                  end
               end
            end
            LOAD: begin
               if (abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state     <= RUN;
                  r_out_valid <= 1'b1;
               end
            end
            RUN: begin
               if (abort) begin
                  r_state     <= IDLE;
                  r_busy      <= 1'b0;
                  r_out_valid <= 1'b0;
               end else if (w_step) begin
                  r_rem   <= r_rem - 1'b1;
                  r_steps <= w_steps_inc;
                  if ((w_next == r_seed) && !r_period_valid) begin
                     r_period       <= w_steps_inc;
                     r_period_valid <= 1'b1;
                  end
                  if (r_rem == CNT_W'(1)) begin
                     r_state     <= DONE;
                     r_done      <= 1'b1;
                     r_out_valid <= 1'b0;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign out_data     = w_q;
   assign out_valid    = r_out_valid;
   assign busy         = r_busy;
   assign done         = r_done;
   assign err          = r_err;
   assign period       = r_period;
   assign period_valid = r_period_valid;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb_lfsr_seq_ctrl: scoreboard bench; stimulus queues expected words/pulses, a negedge monitor
// pops and compares them as the DUT produces them.
module tb_lfsr_seq_ctrl;

   localparam int W = 4;
   localparam int C = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] seed = '0;
   logic [C-1:0] count = '0;
   logic         abort = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         busy;
   logic         done;
   logic         err;
   logic [C-1:0] period;
   logic         period_valid;

   lfsr_seq_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .seed         (seed),
      .count        (count),
      .abort        (abort),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .period       (period),
      .period_valid (period_valid)
   );

   always #5 clk = ~clk;

   typedef enum logic [1:0] {K_WORD, K_DONE, K_ERR} kind_t;
   typedef struct packed {
      kind_t        k;
      logic [W-1:0] d;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // full LFSR cycle from seed 0001, written out by hand
   logic [W-1:0] seq15 [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic pop(input kind_t k, input logic [W-1:0] d, input string nm);
      exp_t e;
      n_vec++;
      if (q.size() == 0) begin
         n_bad++;
         $display("FAIL %s: unexpected output kind %0d data %0h", nm, k, d);
      end else begin
         e = q.pop_front();
         if (e.k !== k || (k == K_WORD && e.d !== d)) begin
            n_bad++;
            $display("FAIL %s: got kind %0d data %0h expected kind %0d data %0h", nm, k, d, e.k, e.d);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready && !abort) pop(K_WORD, out_data, "word");
         if (done) pop(K_DONE, '0, "done");
         if (err)  pop(K_ERR, '0, "err");
      end
   end

   task automatic push(input kind_t k, input logic [W-1:0] d);
      exp_t e;
      e.k = k;
      e.d = d;
      q.push_back(e);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic go(input logic [W-1:0] s, input logic [C-1:0] c);
      seed  = s;
      count = c;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 100) begin
         cyc(1);
         n++;
      end
      chk(nm, {31'd0, busy}, 32'd0);
   endtask

   task automatic run_basic(input string nm);
      push(K_WORD, 4'h1);
      push(K_WORD, 4'h2);
      push(K_WORD, 4'h4);
      push(K_DONE, '0);
      go(4'h1, 16'd3);
      chk({nm, " load valid"}, {31'd0, out_valid}, 32'd0);
      chk({nm, " load busy"}, {31'd0, busy}, 32'd1);
      cyc(1);
      chk({nm, " first valid"}, {27'd0, out_valid, out_data}, {27'd0, 1'b1, 4'h1});
      wait_idle({nm, " idle"});
   endtask

   initial begin
      cyc(2);
      chk("reset outputs", {out_data, out_valid, busy, done, err, period, period_valid},
          {W'(0), 1'b0, 1'b0, 1'b0, 1'b0, C'(0), 1'b0});
      rst = 1'b0;
      cyc(1);

      run_basic("basic");

      push(K_WORD, 4'h1);
      push(K_WORD, 4'h2);
      push(K_WORD, 4'h4);
      push(K_DONE, '0);
      go(4'h1, 16'd3);
      cyc(2);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("stall hold", {27'd0, out_valid, out_data}, {27'd0, 1'b1, 4'h2});
      end
      out_ready = 1'b1;
      wait_idle("stall idle");

      push(K_ERR, '0);
      go(4'h0, 16'd5);
      chk("seed0 busy/valid", {30'd0, busy, out_valid}, 32'd0);
      cyc(1);
      chk("seed0 stays idle", {30'd0, busy, out_valid}, 32'd0);
      push(K_DONE, '0);
      go(4'h3, 16'd0);
      chk("count0 busy/valid", {30'd0, busy, out_valid}, {30'd0, 1'b1, 1'b0});
      cyc(1);
      chk("count0 idle", {30'd0, busy, out_valid}, 32'd0);

      for (int i = 0; i < 20; i++) push(K_WORD, seq15[i % 15]);
      push(K_DONE, '0);
      go(4'h1, 16'd20);
      chk("period cleared", {15'd0, period, period_valid}, 32'd0);
      cyc(15);
      chk("period not yet", {31'd0, period_valid}, 32'd0);
      cyc(1);
      chk("period measured", {15'd0, period, period_valid}, {15'd0, 16'd15, 1'b1});
      wait_idle("long idle");
      chk("period persists", {15'd0, period, period_valid}, {15'd0, 16'd15, 1'b1});

      push(K_WORD, 4'h1);
      go(4'h1, 16'd10);
      cyc(2);
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      chk("abort state", {26'd0, out_valid, busy, out_data}, {26'd0, 1'b0, 1'b0, 4'h2});
      chk("abort period", {31'd0, period_valid}, 32'd0);
      push(K_WORD, 4'h8);
      push(K_WORD, 4'h1);
      push(K_DONE, '0);
      go(4'h8, 16'd2);
      wait_idle("after abort idle");

      for (int i = 0; i < 4; i++) push(K_WORD, seq15[i]);
      go(4'h1, 16'd20);
      cyc(5);
      chk("word5 presented", {27'd0, out_valid, out_data}, {27'd0, 1'b1, 4'h3});
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("mid-run reset", {out_data, out_valid, busy, done, err, period, period_valid},
          {W'(0), 1'b0, 1'b0, 1'b0, 1'b0, C'(0), 1'b0});
      cyc(1);
      run_basic("post reset");

      cyc(3);
      chk("scoreboard drained", q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
